regfile_write_arbiter: RTL

- Shares the register file's single write port between N writeback requesters, e.g. ALU result, load data and jump-and-link.
- Arbitrates round-robin, with a valid/ready handshake per requester.
- Registers the winning request and drives the register file's WriteEnable, WriteRegister and WriteData with one cycle of latency.
- Sits between the pipeline writeback sources and the register file.

---
 rtl/rf_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 55 +++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback path.
//   REG_ADDR_W / REG_DATA_W : default register address and data widths
//   NUM_REGS                : architectural register count
//   ZERO_REG                : hard-wired zero register; writes to it are dropped
//   REQ_ALU/REQ_LOAD/REQ_LINK : writeback requester slot indices
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ZERO_REG   = 0;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_LINK = 2;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback requesters and the register-file write arbiter.
//   ReqValid/ReqReady/ReqAddr/ReqData : per-requester handshake, packed per requester
//   Freeze                            : pipeline stall, blocks grants
//   WriteEnable/WriteRegister/WriteData : registered register-file write port
//   Idle                              : nothing staged and nothing requested
//   Fwd* (only with RFARB_FWD_EN)     : two bypass lookups against the staged write
// Modports: master = requester/pipeline side, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
);

    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ-1:0]        ReqReady;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic                      Freeze;
    logic                      WriteEnable;
    logic [ADDR_W-1:0]         WriteRegister;
    logic [DATA_W-1:0]         WriteData;
    logic                      Idle;

`ifdef RFARB_FWD_EN
    logic [ADDR_W-1:0] FwdAddr1;
    logic [ADDR_W-1:0] FwdAddr2;
    logic              FwdHit1;
    logic              FwdHit2;
    logic [DATA_W-1:0] FwdData1;
    logic [DATA_W-1:0] FwdData2;

    modport master (
        output ReqValid, ReqAddr, ReqData, Freeze, FwdAddr1, FwdAddr2,
        input  ReqReady, WriteEnable, WriteRegister, WriteData, Idle,
               FwdHit1, FwdHit2, FwdData1, FwdData2
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData, Freeze, FwdAddr1, FwdAddr2,
        output ReqReady, WriteEnable, WriteRegister, WriteData, Idle,
               FwdHit1, FwdHit2, FwdData1, FwdData2
    );
`else
    modport master (
        output ReqValid, ReqAddr, ReqData, Freeze,
        input  ReqReady, WriteEnable, WriteRegister, WriteData, Idle
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData, Freeze,
        output ReqReady, WriteEnable, WriteRegister, WriteData, Idle
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this cycle (held by the parent)
//   grant : one-hot winner, zero when no request
//   gidx  : encoded winner index
//   valid : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   gidx,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    // Walk from ptr upward with wrap; the first set request wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NUM_REQ writeback sources. The winning request is staged in a register and
// presented to the register file one cycle after the handshake.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : regfile_write_arbiter_if slave modport (handshake, write port, Idle)
// Optional build macro RFARB_FWD_EN adds two combinational forwarding lookups
// (FwdAddr1/2 -> FwdHit1/2, FwdData1/2) against the staged write.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   gidx;
    logic               any_req;
    logic               grant_en;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (bus.ReqValid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .valid (any_req)
    );

    // Grants are suppressed while stalled and while reset is held.
    assign grant_en     = ~rst & ~bus.Freeze;
    assign bus.ReqReady = grant & {NUM_REQ{grant_en}};
    assign xfer         = grant_en & any_req;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.ReqAddr[i*ADDR_W +: ADDR_W];
                sel_data = bus.ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Address/data hold when idle; only the enable is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (xfer) begin
            ptr_q  <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            // A zero-register write still consumes its slot but never reaches the file.
            we_q   <= (sel_addr != ADDR_W'(ZERO_REG));
            addr_q <= sel_addr;
            data_q <= sel_data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    assign bus.WriteEnable   = we_q;
    assign bus.WriteRegister = addr_q;
    assign bus.WriteData     = data_q;
    assign bus.Idle          = ~we_q & ~(|bus.ReqValid);

`ifdef RFARB_FWD_EN
    logic hit1;
    logic hit2;

    assign hit1 = we_q & (addr_q == bus.FwdAddr1) & (bus.FwdAddr1 != ADDR_W'(ZERO_REG));
    assign hit2 = we_q & (addr_q == bus.FwdAddr2) & (bus.FwdAddr2 != ADDR_W'(ZERO_REG));

    assign bus.FwdHit1  = hit1;
    assign bus.FwdHit2  = hit2;
    assign bus.FwdData1 = hit1 ? data_q : '0;
    assign bus.FwdData2 = hit2 ? data_q : '0;
`endif

endmodule
